fir_out_quantizer: RTL and testbench
====================================

// Module: fir_out_quantizer
// PURPOSE
//  Output stage directly downstream of the FIR accumulator. Takes each full-precision
//  signed accumulator result, then rounds it, scales it (arithmetic shift) and saturates it
//  to 16 bits. Results are buffered in a small FIFO behind a valid/ready output handshake,
//  so the sample sink can stall without losing data. A saturation event counter is kept for debug.
// PARAMETERS
//  ACCUBITS    41  width of signed accumulator input (MULTBITS 32 + clog2(401 taps))
//  SHIFT       15  right-shift applied after rounding (Q15 coefficients); legal 0..ACCUBITS-2
//  FIFO_DEPTH  4   output FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         synchronous, active-low reset
//  in_valid    in   1         in_data holds a valid accumulator result
//  in_ready    out  1         block can accept in_data this cycle
//  in_data     in   ACCUBITS  signed accumulator result
//  out_valid   out  1         out_sample holds FIFO head
//  out_ready   in   1         sink accepts out_sample this cycle
//  out_sample  out  16        signed rounded/saturated sample
//  sat_count   out  16        number of saturated results, sticks at 16'hFFFF
// BEHAVIOUR
//  - Reset (rst==0 at posedge): FIFO emptied (count=0, pointers=0), s1_valid=0, sat_count=0.
//    While in reset and on the first cycle after it: out_valid=0, in_ready=1, out_sample=0.
//  - Handshake: a transfer occurs on any edge where valid&&ready. in_ready and out_valid
//    are functions of registers only. They never depend combinationally on in_valid or out_ready.
//  - Stage 1 (register s1): captures the quantized in_data when in_valid&&in_ready; otherwise
//    s1_valid<=0.
//  - Quantize: sum = in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in ACCUBITS+1 bits.
//    q = sum >>> SHIFT (arithmetic). Rounding is round-half-up toward +inf.
//    If q > 32767, out = 32767. If q < -32768, out = -32768. Otherwise out = q[15:0].
//  - Saturation: sat_count increments when a saturating sample is captured into s1.
//    It holds once it reaches 16'hFFFF.
//  - FIFO write: every edge with s1_valid=1 writes s1 into the FIFO. Space for the write is
//    guaranteed by the credit rule below.
//  - Credit rule: in_ready = (count + s1_valid) < FIFO_DEPTH.
//  - FIFO read: out_valid = (count != 0). out_sample = mem[rd_ptr], read combinationally from
//    registers, and equals 0 when empty. Pop occurs on out_valid&&out_ready.
//  - Simultaneous push and pop: count is unchanged and both pointers advance (wrap mod FIFO_DEPTH).
//    When count==0 and s1 is writing, the new data is not visible until the next cycle
//    (no bypass).
//  - Latency: input accepted at edge k -> out_valid with that sample after edge k+1
//    (2-cycle minimum). Throughput is 1 sample/cycle when out_ready is held high.
//  - Order: samples leave strictly in acceptance order. None are dropped or duplicated.
//  - Reset mid-operation: all queued and in-flight samples are discarded. No output appears
//    for data accepted before reset.
//  - out_sample is held stable while out_valid=1 and out_ready=0.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, sat_count=0.
//    Release rst -> first output appears 2 cycles after the first accepted input.
//  2 Rounding (SHIFT=15), out_ready=1: in_data 16384 -> 1. -16384 -> 0. -16385 -> -1.
//    1073709056 -> 32767. 49152 -> 2. Each appears 2 cycles after acceptance. sat_count stays 0.
//  3 Saturation: in_data 2^40-1 -> 32767. -2^40 -> -32768. 1073725440 -> 32767.
//    sat_count=3 after all three inputs.
//  4 Backpressure: out_ready=0, in_valid=1 with values 1..6 (<<15) -> exactly 4 accepted.
//    in_ready=0 from the cycle after the 4th acceptance. out_sample holds 1.
//    Set out_ready=1 -> outputs 1,2,3,4,5,6 in order with no gaps or duplicates.
//  5 Streaming: out_ready and in_valid both toggled randomly over 1000 samples. Compare
//    against the golden quantize model -> exact sequence match. in_ready never drops while
//    count+s1_valid<4.
//  6 Reset mid-operation: 3 samples queued plus 1 in s1, pulse rst=0 for 1 cycle ->
//    out_valid=0 next cycle and none of the 4 samples ever emitted. sat_count=0.

Source files
------------

// File: rtl/fir_out_quantizer_if.sv
// Stream bundle between the FIR accumulator, the output quantizer and the sample sink.
// The quantizer uses the slave view; the driving side (accumulator plus sink) uses the master view.
interface fir_out_quantizer_if #(
    parameter int ACCUBITS = 41
);
    logic                in_valid;
    logic                in_ready;
    logic [ACCUBITS-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_sample;
    logic [15:0]         sat_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sample, sat_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sample, sat_count
    );
endinterface

// File: rtl/fir_out_quantizer.sv
// Rounds, shifts and saturates signed FIR accumulator results to 16 bits.
// Results pass through one register stage into a small credit-protected output FIFO.
module fir_out_quantizer #(
    parameter int ACCUBITS   = 41,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fir_out_quantizer_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = ACCUBITS + 1;
    localparam logic signed [SW-1:0] RND  = SW'((SHIFT > 0) ? (64'd1 << (SHIFT - 1)) : 64'd0);
    localparam logic signed [SW-1:0] MAXV = SW'(32767);
    localparam logic signed [SW-1:0] MINV = SW'(-32768);

    logic              r_s1_valid;
    logic [15:0]       r_s1_data;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [15:0]       r_sat_count;

    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_q;
    logic                 w_sat_hi;
    logic                 w_sat_lo;
    logic [15:0]          w_qsample;
    logic [AW+1:0]        w_occupancy;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;

    // Widen by one bit so the rounding constant can never overflow the sum.
    always_comb begin
        w_sum     = $signed({bus.in_data[ACCUBITS-1], bus.in_data}) + RND;
        w_q       = w_sum >>> SHIFT;
        w_sat_hi  = (w_q > MAXV);
        w_sat_lo  = (w_q < MINV);
        w_qsample = w_sat_hi ? 16'h7FFF : (w_sat_lo ? 16'h8000 : w_q[15:0]);
    end

    // Handshake: a word moves on every rising edge where valid && ready. in_ready and
    // out_valid come from registers only, so neither side sees a combinational loop.
    // in_ready counts the s1 word as already occupying a FIFO slot, which reserves its space.
    always_comb begin
        w_occupancy    = {1'b0, r_count} + (AW+2)'(r_s1_valid);
        bus.in_ready   = (w_occupancy < (AW+2)'(FIFO_DEPTH));
        bus.out_valid  = (r_count != '0);
        bus.out_sample = bus.out_valid ? r_mem[r_rd_ptr] : 16'h0000;
        bus.sat_count  = r_sat_count;
        w_accept       = bus.in_valid && bus.in_ready;
        w_push         = r_s1_valid;
        w_pop          = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= 16'h0000;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_sat_count <= 16'h0000;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_qsample;
            end
            if (w_accept && (w_sat_hi || w_sat_lo) && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= r_s1_data;
        end
    end
endmodule

// File: tb/tb_fir_out_quantizer.sv
// Self-checking bench for fir_out_quantizer: directed rounding/saturation cases,
// backpressure, a random stream against an arithmetic reference, and a mid-stream reset.
module tb_fir_out_quantizer;
    localparam int ACCUBITS   = 41;
    localparam int SHIFT      = 15;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic rst;

    fir_out_quantizer_if #(.ACCUBITS(ACCUBITS)) bus ();

    fir_out_quantizer #(
        .ACCUBITS   (ACCUBITS),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_sat   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: floor((v + 2^(SHIFT-1)) / 2^SHIFT), then clamp to the int16 range.
    function automatic longint ref_quant(input logic [ACCUBITS-1:0] d);
        longint v;
        longint s;
        longint dv;
        longint q;
        v  = longint'($signed(d));
        dv = longint'(1) <<< SHIFT;
        s  = v + ((SHIFT > 0) ? (dv / 2) : 0);
        q  = s / dv;
        if ((s < 0) && ((s % dv) != 0)) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic bit ref_sat(input logic [ACCUBITS-1:0] d);
        longint v;
        longint s;
        longint dv;
        longint q;
        v  = longint'($signed(d));
        dv = longint'(1) <<< SHIFT;
        s  = v + ((SHIFT > 0) ? (dv / 2) : 0);
        q  = s / dv;
        if ((s < 0) && ((s % dv) != 0)) q = q - 1;
        return (q > 32767) || (q < -32768);
    endfunction

    // One clock of stimulus plus scoreboard. Outputs depend only on registers,
    // so sampling right after driving at the falling edge is race-free.
    task automatic cycle(input bit iv, input logic [ACCUBITS-1:0] d, input bit ordy, output bit acc);
        logic [15:0] e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        check("credit_in_ready", longint'(bus.in_ready), longint'(exp_q.size() < FIFO_DEPTH));
        check("sat_count", longint'(bus.sat_count), longint'(m_sat));
        acc = iv && bus.in_ready;
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("stream_sample", longint'($signed(bus.out_sample)), longint'($signed(e)));
            end
        end
        if (acc) begin
            exp_q.push_back(16'(ref_quant(d)));
            if (ref_sat(d)) m_sat++;
        end
    endtask

    // Single isolated transfer with out_ready high, timing checked explicitly.
    task automatic direct(input string tag, input longint d, input longint expv);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d[ACCUBITS-1:0];
        bus.out_ready = 1'b1;
        check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_early_valid"}, longint'(bus.out_valid), 0);
        @(negedge clk);
        check({tag, "_valid"}, longint'(bus.out_valid), 1);
        check(tag, longint'($signed(bus.out_sample)), expv);
    endtask

    logic [ACCUBITS-1:0] bp_vals[6];
    logic [ACCUBITS-1:0] rd;
    longint              v;
    bit                  acc;
    int                  idx;
    int                  n_acc;
    int                  budget;

    initial begin
        // 1: reset held with in_valid asserted
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 41'd16384;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", longint'(bus.out_valid), 0);
            check("rst_in_ready", longint'(bus.in_ready), 1);
            check("rst_sat_count", longint'(bus.sat_count), 0);
            check("rst_out_sample", longint'(bus.out_sample), 0);
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        check("post_rst_in_ready", longint'(bus.in_ready), 1);

        // 2: rounding
        direct("round_16384", 16384, 1);
        direct("round_m16384", -16384, 0);
        direct("round_m16385", -16385, -1);
        direct("round_big", 1073709056, 32767);
        direct("round_49152", 49152, 2);
        @(negedge clk);
        check("round_sat_count", longint'(bus.sat_count), 0);

        // 3: saturation
        direct("sat_pos_max", (longint'(1) <<< 40) - 1, 32767);
        direct("sat_neg_min", -(longint'(1) <<< 40), -32768);
        direct("sat_round_up", 1073725440, 32767);
        @(negedge clk);
        check("sat_count_3", longint'(bus.sat_count), 3);
        m_sat = 3;

        // 4: backpressure
        for (int i = 0; i < 6; i++) bp_vals[i] = ACCUBITS'(longint'(i + 1) <<< 15);
        idx = 0;
        repeat (8) begin
            cycle(idx < 6, bp_vals[(idx < 6) ? idx : 0], 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx, 4);
        check("bp_in_ready_low", longint'(bus.in_ready), 0);
        check("bp_out_valid", longint'(bus.out_valid), 1);
        check("bp_head_held", longint'($signed(bus.out_sample)), 1);
        budget = 0;
        while (((idx < 6) || (exp_q.size() != 0)) && (budget < 50)) begin
            cycle(idx < 6, bp_vals[(idx < 6) ? idx : 0], 1'b1, acc);
            if (acc) idx++;
            budget++;
        end
        check("bp_drained", longint'(exp_q.size()), 0);
        check("bp_all_sent", idx, 6);

        // 5: random stream
        n_acc  = 0;
        budget = 0;
        while ((n_acc < 1000) && (budget < 20000)) begin
            case ($urandom_range(0, 3))
                0: v = longint'($urandom_range(0, 32'h0020_0000)) - 64'sh0010_0000;
                1: v = longint'(int'($urandom)) >>> 1;
                2: v = longint'({$urandom, $urandom});
                default: v = (longint'($urandom_range(0, 65535)) - 32768) * 32768 + 16384
                             - longint'($urandom_range(0, 1));
            endcase
            rd = v[ACCUBITS-1:0];
            cycle($urandom_range(0, 9) < 7, rd, $urandom_range(0, 3) != 0, acc);
            if (acc) n_acc++;
            budget++;
        end
        check("stream_accept_count", n_acc, 1000);
        budget = 0;
        while ((exp_q.size() != 0) && (budget < 100)) begin
            cycle(1'b0, '0, 1'b1, acc);
            budget++;
        end
        check("stream_drained", longint'(exp_q.size()), 0);

        // 6: reset mid-operation with three queued and one in s1
        idx    = 0;
        budget = 0;
        while ((idx < 4) && (budget < 20)) begin
            cycle(1'b1, ACCUBITS'(longint'(1) <<< 39), 1'b0, acc);
            if (acc) idx++;
            budget++;
        end
        check("mid_rst_loaded", idx, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_out_valid", longint'(bus.out_valid), 0);
        check("mid_rst_in_ready", longint'(bus.in_ready), 1);
        check("mid_rst_sat_count", longint'(bus.sat_count), 0);
        check("mid_rst_out_sample", longint'(bus.out_sample), 0);
        exp_q.delete();
        m_sat = 0;
        repeat (20) cycle(1'b0, '0, 1'b1, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
